uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequences the UART receiver: generates its 16x oversampling rx_tick, holds parity config and
//  applies changes only between frames, queues completed frames with error flags in a FIFO,
//  keeps saturating error counters, and resets a hung receiver via watchdog. Between receiver and host.
// PARAMETERS
//  DATA_WIDTH   8    frame payload bits; must equal receiver data_width
//  FIFO_DEPTH   8    RX queue entries; power of 2, >=2
//  DIV_WIDTH    16   baud divisor width
//  DEFAULT_DIV  27   divisor after reset (50 MHz / (115200*16))
// PORTS
//  clk            in   1           system clock
//  rst            in   1           async active-low reset
//  cfg_wr         in   1           pulse: capture cfg_* into shadow
//  cfg_div        in   DIV_WIDTH   clocks per rx_tick; 0 treated as 1
//  cfg_parity_en  in   1           parity enable
//  cfg_odd_even   in   1           parity select to receiver
//  clr_status     in   1           clear counters and overflow
//  rx             in   1           serial line (already synchronised), monitored
//  rx_tick        out  1           1-clk oversample enable to receiver
//  rx_rst         out  1           active-low receiver reset
//  rx_parity_en   out  1           applied parity enable
//  rx_odd_even    out  1           applied parity select
//  rx_done        in   1           receiver frame-complete pulse
//  rx_data        in   DATA_WIDTH  receiver data_out
//  rx_perr        in   1           receiver parity_error
//  rx_ferr        in   1           receiver framing_error
//  out_valid      out  1           FIFO head valid
//  out_data       out  DATA_WIDTH  head payload
//  out_perr       out  1           head parity-error flag
//  out_ferr       out  1           head framing-error flag
//  out_ready      in   1           pop head when out_valid&&out_ready
//  overflow       out  1           sticky: frame dropped on full FIFO
//  perr_cnt       out  8           saturating parity-error count
//  ferr_cnt       out  8           saturating framing-error count (rising edge of rx_ferr)
//  tmo_cnt        out  8           saturating watchdog-timeout count
// BEHAVIOUR
//  Reset: rx_tick=0, rx_rst=0 then 1 on first clk, rx_parity_en=0, rx_odd_even=0, divisor=DEFAULT_DIV,
//   FIFO empty, out_valid=0, out_data/out_perr/out_ferr=0, overflow=0, all counters 0, FSM IDLE.
//  Baud: counter 0..div-1, rx_tick=1 for one clk when count==div-1, then wraps; div=0 -> tick every clk.
//  FSM IDLE->ACTIVE on rx_tick&&rx==0; ACTIVE->IDLE on rx_done; ACTIVE->RECOV on watchdog expiry;
//   RECOV drives rx_rst=0 for exactly 2 clks -> ARM; ARM->IDLE on rx_tick&&rx==1 (no re-entry while line low).
//  Watchdog: counts rx_ticks in ACTIVE, cleared on entry; expiry at 16*(DATA_WIDTH+4) ticks; tmo_cnt++.
//  Config: cfg_wr loads shadow and sets pending (later cfg_wr overwrites). Applied in any clk with FSM in
//   IDLE or ARM: rx_parity_en/rx_odd_even/divisor update, baud counter zeroed, pending cleared. cfg_wr in IDLE
//   applies next clk. Frame in flight always completes with old config.
//  Capture: on rx_done, next clk pushes {rx_ferr,rx_perr,rx_data}; rx_perr counts only if rx_parity_en.
//   out_valid rises 1 clk after rx_done when FIFO was empty. Push+pop same clk when full: both accepted.
//   Push on full without pop: frame dropped, overflow=1, FIFO unchanged.
//  Head: out_data/out_*err stable while out_valid&&!out_ready. Pop on empty ignored.
//  Counters saturate at 255. clr_status zeroes counters/overflow; a same-clk increment is lost.
//  rx_done during RECOV/ARM ignored (not pushed). Reset mid-frame: everything to reset values, FIFO flushed.
// STRUCTURE
//  uart_pkg: FSM state encodings (IDLE,ACTIVE,RECOV,ARM), entry width DATA_WIDTH+2, watchdog limit function.
//  Sub-module uart_sync_fifo (param width/depth, push/pop/full/empty, simultaneous push+pop when full).
//  Baud counter, config shadow, FSM/watchdog, counters stay inline.
// TESTING
//  div=3, idle line -> rx_tick every 3rd clk exactly; cfg_div=0 -> tick every clk.
//  Frame 0xA5 odd parity ok -> one entry {0,0,0xA5}, out_valid 1 clk after rx_done, counters 0.
//  Bad parity then stop bit 0 then 1 -> entry {1,1,data}, perr_cnt=1, ferr_cnt=1.
//  cfg_wr parity_en=1 mid-frame -> rx_parity_en unchanged until rx_done, then applies in IDLE.
//  9 frames, out_ready=0, depth 8 -> 8 entries, overflow=1, 9th lost; drain in order; push+pop at full holds count 8.
//  Force rx_done never -> rx_rst low 2 clks after 16*12 ticks, tmo_cnt=1; line held low -> no re-arm until rx=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller: FSM states,
// FIFO entry sizing, watchdog limit and a saturating-increment helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_RECOV  = 2'd2,
    ST_ARM    = 2'd3
  } rx_state_t;

  localparam int unsigned OVERSAMPLE     = 16;
  localparam int unsigned FRAME_OVERHEAD = 4;
  localparam int unsigned RECOV_CLKS     = 2;
  localparam int unsigned CNT_WIDTH      = 8;

  // Entry layout is {ferr, perr, data}.
  function automatic int unsigned entry_width(input int unsigned dw);
    return dw + 2;
  endfunction

  // Generous bound: a full frame plus margin, counted in oversample ticks.
  function automatic int unsigned wdog_limit(input int unsigned dw);
    return OVERSAMPLE * (dw + FRAME_OVERHEAD);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted when a pop happens in the same clock.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             push_ok;
  logic             pop_ok;

  // Extra pointer MSB distinguishes full from empty when indices match.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversample tick generation, between-frame config
// application, frame queueing with error flags, error counters and watchdog.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned DEFAULT_DIV = 27
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [DIV_WIDTH-1:0]  cfg_div,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_odd_even,
  input  logic                  clr_status,
  input  logic                  rx,
  output logic                  rx_tick,
  output logic                  rx_rst,
  output logic                  rx_parity_en,
  output logic                  rx_odd_even,
  input  logic                  rx_done,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_perr,
  input  logic                  rx_ferr,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_perr,
  output logic                  out_ferr,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic [7:0]            perr_cnt,
  output logic [7:0]            ferr_cnt,
  output logic [7:0]            tmo_cnt
);

  localparam int unsigned ENTRY_W  = entry_width(DATA_WIDTH);
  localparam int unsigned WD_LIMIT = wdog_limit(DATA_WIDTH);
  localparam int unsigned WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

  rx_state_t state_reg, state_next;

  logic [DIV_WIDTH-1:0] div_reg, baud_cnt_reg, div_eff;
  logic [DIV_WIDTH-1:0] sh_div_reg;
  logic                 sh_parity_en_reg, sh_odd_even_reg, pending_reg;
  logic                 parity_en_reg, odd_even_reg;
  logic [WD_W-1:0]      wdog_cnt_reg;
  logic [1:0]           recov_cnt_reg;
  logic                 rx_rst_reg;
  logic                 ferr_prev_reg;
  logic                 overflow_reg;

  logic start_frame, apply_cfg, wdog_expire;
  logic done_accept, fifo_full, fifo_empty, drop;
  logic [ENTRY_W-1:0] fifo_head;

  // ---------------- baud tick ----------------
  assign div_eff = (div_reg == '0) ? DIV_WIDTH'(1) : div_reg;
  assign rx_tick = (baud_cnt_reg == div_eff - DIV_WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_cnt_reg <= '0;
    end else if (apply_cfg || rx_tick) begin
      baud_cnt_reg <= '0;
    end else begin
      baud_cnt_reg <= baud_cnt_reg + DIV_WIDTH'(1);
    end
  end

  // ---------------- config shadow ----------------
  // A tick that starts a frame blocks the apply so the new frame keeps old settings.
  assign start_frame = (state_reg == ST_IDLE) && rx_tick && !rx;
  assign apply_cfg   = pending_reg &&
                       (((state_reg == ST_IDLE) && !start_frame) || (state_reg == ST_ARM));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_div_reg       <= DIV_RST;
      sh_parity_en_reg <= 1'b0;
      sh_odd_even_reg  <= 1'b0;
      pending_reg      <= 1'b0;
      div_reg          <= DIV_RST;
      parity_en_reg    <= 1'b0;
      odd_even_reg     <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_div_reg       <= cfg_div;
        sh_parity_en_reg <= cfg_parity_en;
        sh_odd_even_reg  <= cfg_odd_even;
      end
      if (apply_cfg) begin
        div_reg       <= sh_div_reg;
        parity_en_reg <= sh_parity_en_reg;
        odd_even_reg  <= sh_odd_even_reg;
      end
      pending_reg <= cfg_wr || (pending_reg && !apply_cfg);
    end
  end

  assign rx_parity_en = parity_en_reg;
  assign rx_odd_even  = odd_even_reg;

  // ---------------- FSM / watchdog ----------------
  always_comb begin
    state_next  = state_reg;
    wdog_expire = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_frame) state_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (rx_done) begin
          state_next = ST_IDLE;
        end else if (rx_tick && (wdog_cnt_reg == WD_W'(WD_LIMIT - 1))) begin
          state_next  = ST_RECOV;
          wdog_expire = 1'b1;
        end
      end
      ST_RECOV: begin
        if (recov_cnt_reg == 2'(RECOV_CLKS - 1)) state_next = ST_ARM;
      end
      ST_ARM: begin
        if (rx_tick && rx) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      wdog_cnt_reg  <= '0;
      recov_cnt_reg <= '0;
      rx_rst_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg != ST_ACTIVE) begin
        wdog_cnt_reg <= '0;
      end else if (rx_tick) begin
        wdog_cnt_reg <= wdog_cnt_reg + WD_W'(1);
      end
      recov_cnt_reg <= (state_reg == ST_RECOV) ? recov_cnt_reg + 2'd1 : 2'd0;
      rx_rst_reg    <= (state_next != ST_RECOV);
    end
  end

  assign rx_rst = rx_rst_reg;

  // ---------------- frame queue ----------------
  assign done_accept = rx_done && ((state_reg == ST_IDLE) || (state_reg == ST_ACTIVE));
  assign drop        = done_accept && fifo_full && !out_ready;

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (done_accept),
    .push_data ({rx_ferr, rx_perr, rx_data}),
    .pop       (out_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head[DATA_WIDTH-1:0];
  assign out_perr  = fifo_head[DATA_WIDTH];
  assign out_ferr  = fifo_head[DATA_WIDTH+1];

  // ---------------- status ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ferr_prev_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      ferr_prev_reg <= rx_ferr;
      if (clr_status) begin
        overflow_reg <= 1'b0;
      end else if (drop) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign overflow = overflow_reg;

  // Counter order: 0 parity, 1 framing (edge of rx_ferr), 2 watchdog timeout.
  logic [2:0]             cnt_inc;
  logic [3*CNT_WIDTH-1:0] cnt_flat;

  assign cnt_inc = {wdog_expire,
                    rx_ferr && !ferr_prev_reg,
                    done_accept && rx_perr && parity_en_reg};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    logic [CNT_WIDTH-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_reg <= '0;
      end else if (clr_status) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi]) begin
        cnt_reg <= sat_inc(cnt_reg);
      end
    end
    assign cnt_flat[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg;
  end

  assign perr_cnt = cnt_flat[0*CNT_WIDTH +: CNT_WIDTH];
  assign ferr_cnt = cnt_flat[1*CNT_WIDTH +: CNT_WIDTH];
  assign tmo_cnt  = cnt_flat[2*CNT_WIDTH +: CNT_WIDTH];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: baud table, directed frame/config/
// overflow/watchdog sequences, and randomized traffic against a queue model.
module tb_uart_rx_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int DIVW  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            cfg_wr = 1'b0;
  logic [DIVW-1:0] cfg_div = '0;
  logic            cfg_parity_en = 1'b0;
  logic            cfg_odd_even = 1'b0;
  logic            clr_status = 1'b0;
  logic            rx = 1'b1;
  logic            rx_tick, rx_rst, rx_parity_en, rx_odd_even;
  logic            rx_done = 1'b0;
  logic [DW-1:0]   rx_data = '0;
  logic            rx_perr = 1'b0;
  logic            rx_ferr = 1'b0;
  logic            out_valid, out_perr, out_ferr, overflow;
  logic [DW-1:0]   out_data;
  logic            out_ready = 1'b1;
  logic [7:0]      perr_cnt, ferr_cnt, tmo_cnt;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .DIV_WIDTH  (DIVW),
    .DEFAULT_DIV(27)
  ) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_div(cfg_div),
    .cfg_parity_en(cfg_parity_en), .cfg_odd_even(cfg_odd_even),
    .clr_status(clr_status), .rx(rx), .rx_tick(rx_tick), .rx_rst(rx_rst),
    .rx_parity_en(rx_parity_en), .rx_odd_even(rx_odd_even),
    .rx_done(rx_done), .rx_data(rx_data), .rx_perr(rx_perr), .rx_ferr(rx_ferr),
    .out_valid(out_valid), .out_data(out_data), .out_perr(out_perr),
    .out_ferr(out_ferr), .out_ready(out_ready), .overflow(overflow),
    .perr_cnt(perr_cnt), .ferr_cnt(ferr_cnt), .tmo_cnt(tmo_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {ferr,perr,data}, sticky overflow, counters.
  logic [9:0] mq[$];
  bit m_ovf, m_ferr_prev, m_parity_en, m_accept;
  int m_perr, m_ferr;

  typedef struct {
    logic [DIVW-1:0] div;
    int              gap;
  } baud_vec_t;
  baud_vec_t bv[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_perr = 0; m_ferr = 0; m_ferr_prev = 0;
  endtask

  task automatic model_edge();
    bit pop, push, rise;
    if (!rst) begin
      model_reset();
      return;
    end
    pop  = out_ready && (mq.size() > 0);
    push = 0;
    if (rx_done && m_accept) begin
      if (mq.size() < DEPTH || pop) push = 1;
      else if (!clr_status) m_ovf = 1;
    end
    rise = rx_ferr && !m_ferr_prev;
    if (clr_status) begin
      m_ovf = 0; m_perr = 0; m_ferr = 0;
    end else begin
      if (rx_done && m_accept && rx_perr && m_parity_en && m_perr < 255) m_perr++;
      if (rise && m_ferr < 255) m_ferr++;
    end
    m_ferr_prev = rx_ferr;
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back({rx_ferr, rx_perr, rx_data});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [9:0] h;
    h = (mq.size() > 0) ? mq[0] : 10'd0;
    check({tag, ".valid"}, out_valid, mq.size() > 0);
    check({tag, ".data"},  out_data, h[7:0]);
    check({tag, ".perr"},  out_perr, h[8]);
    check({tag, ".ferr"},  out_ferr, h[9]);
    check({tag, ".ovf"},   overflow, m_ovf);
    check({tag, ".pcnt"},  perr_cnt, m_perr);
    check({tag, ".fcnt"},  ferr_cnt, m_ferr);
  endtask

  task automatic set_cfg(input logic [DIVW-1:0] d, input bit pe, input bit oe);
    cfg_div = d; cfg_parity_en = pe; cfg_odd_even = oe; cfg_wr = 1;
    step();
    cfg_wr = 0;
  endtask

  task automatic start_frame(input bit keep_low);
    int n;
    n = 0;
    rx = 0;
    while (!rx_tick && n < 200) begin
      step();
      n++;
    end
    check("frame_start_tick", rx_tick, 1);
    step();
    if (!keep_low) rx = 1;
  endtask

  task automatic send_done(input logic [7:0] d, input bit pe, input bit fe);
    rx_done = 1; rx_data = d; rx_perr = pe; rx_ferr = fe;
    step();
    rx_done = 0; rx_perr = 0; rx_ferr = 0;
  endtask

  initial begin
    int n;
    m_accept = 1; m_parity_en = 0;
    model_reset();
    bv[0] = '{16'd3, 3};
    bv[1] = '{16'd0, 1};
    bv[2] = '{16'd1, 1};
    bv[3] = '{16'd5, 5};
    bv[4] = '{16'd27, 27};

    // reset state
    step(); step();
    check("rst.tick", rx_tick, 0);
    check("rst.rx_rst", rx_rst, 0);
    check("rst.par_en", rx_parity_en, 0);
    check("rst.odd", rx_odd_even, 0);
    check("rst.tmo", tmo_cnt, 0);
    check_all("rst");
    rst = 1;
    step();
    check("rst.rx_rst_release", rx_rst, 1);

    // baud table: after apply the counter restarts at 0
    for (int v = 0; v < 5; v++) begin
      set_cfg(bv[v].div, 0, 0);
      step();
      for (int i = 0; i < 3 * bv[v].gap; i++) begin
        check($sformatf("tick_div%0d_i%0d", bv[v].div, i), rx_tick, ((i + 1) % bv[v].gap) == 0);
        step();
      end
      $display("baud div=%0d period=%0d checked", bv[v].div, bv[v].gap);
    end

    // parity config applies one clock after cfg_wr in IDLE
    set_cfg(16'd2, 1, 1);
    check("cfg_idle_not_yet", rx_parity_en, 0);
    step();
    check("cfg_idle_par", rx_parity_en, 1);
    check("cfg_idle_odd", rx_odd_even, 1);
    m_parity_en = 1;

    // good frame 0xA5
    start_frame(0);
    step();
    check("a5.pre_valid", out_valid, 0);
    send_done(8'hA5, 0, 0);
    check("a5.data", out_data, 8'hA5);
    check_all("a5");
    $display("frame data=a5 perr=0 ferr=0");
    step();

    // bad parity + framing error
    start_frame(0);
    send_done(8'h3C, 1, 1);
    check_all("bad");
    check("bad.pcnt", perr_cnt, 1);
    check("bad.fcnt", ferr_cnt, 1);
    $display("frame data=3c perr=1 ferr=1");
    step();

    // config written mid-frame waits until frame end
    start_frame(0);
    set_cfg(16'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("mid.hold", rx_parity_en, 1);
      step();
    end
    send_done(8'h5A, 1, 0);
    check("mid.after_done", rx_parity_en, 1);
    check("mid.pcnt", perr_cnt, 2);
    step();
    check("mid.applied", rx_parity_en, 0);
    m_parity_en = 0;
    step();

    // overflow: 9 frames with no pops
    out_ready = 0;
    for (int i = 0; i < 9; i++) begin
      send_done(8'($urandom), 1'($urandom), 1'($urandom));
      check_all($sformatf("fill%0d", i));
    end
    check("ovf.sticky", overflow, 1);
    rx_done = 1; rx_data = 8'hE7; out_ready = 1;
    step();
    rx_done = 0; out_ready = 1;
    check_all("pushpop_full");
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) n++;
      check_all($sformatf("drain%0d", i));
      step();
    end
    check("drain.count", n, 8);
    clr_status = 1; step(); clr_status = 0;
    check_all("clr");

    // randomized traffic with parity counting enabled
    set_cfg(16'd2, 1, 0);
    step();
    m_parity_en = 1;
    for (int i = 0; i < 400; i++) begin
      rx_done    = ($urandom % 3) == 0;
      rx_data    = 8'($urandom);
      rx_perr    = 1'($urandom);
      rx_ferr    = 1'($urandom);
      out_ready  = ($urandom % 4) != 0;
      clr_status = ($urandom % 50) == 0;
      step();
      check_all("rand");
    end
    rx_done = 0; rx_ferr = 0; rx_perr = 0; clr_status = 0; out_ready = 1;

    // saturation
    clr_status = 1; step(); clr_status = 0;
    for (int i = 0; i < 600; i++) begin
      rx_done = 1; rx_perr = 1; rx_ferr = i[0];
      step();
    end
    rx_done = 0; rx_perr = 0; rx_ferr = 0;
    step(); step();
    check("sat.pcnt", perr_cnt, 255);
    check("sat.fcnt", ferr_cnt, 255);
    check_all("sat");

    // watchdog: frame never completes
    set_cfg(16'd1, 1, 0);
    step();
    clr_status = 1; step(); clr_status = 0;
    check("wd.tmo0", tmo_cnt, 0);
    start_frame(1);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (!rx_rst) break;
      if (rx_tick) n++;
      step();
    end
    check("wd.rx_rst_low", rx_rst, 0);
    check("wd.ticks", n, 192);
    check("wd.tmo1", tmo_cnt, 1);
    $display("watchdog expired after %0d ticks", n);
    m_accept = 0;
    send_done(8'h77, 0, 0);
    check("wd.recov2", rx_rst, 0);
    step();
    check("wd.recov_end", rx_rst, 1);
    for (int i = 0; i < 5; i++) step();
    send_done(8'h55, 0, 0);
    check_all("arm_low");
    rx = 1;
    step(); step();
    m_accept = 1;
    send_done(8'h66, 0, 0);
    check("rearm.data", out_data, 8'h66);
    check_all("rearm");

    // asynchronous reset mid-frame flushes everything
    out_ready = 0;
    start_frame(0);
    send_done(8'h12, 1, 1);
    rst = 0;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.rx_rst", rx_rst, 0);
    check("async_rst.tmo", tmo_cnt, 0);
    check("async_rst.par", rx_parity_en, 0);
    step();
    rst = 1;
    step();
    check("post_rst.rx_rst", rx_rst, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
